y_zigzag_rle: RTL and testbench

Luminance zig-zag scanner and run-length coder, placed directly downstream of the Y quantizer. It captures each 8x8 block of 11-bit signed quantized coefficients when the quantizer's one-cycle valid pulse arrives. It then emits a serial stream of JPEG-style symbols: one DC difference symbol, followed by (run, size, value) AC symbols with ZRL and EOB. The stream goes to the Huffman encoder through a valid/ready handshake.

---
 rtl/y_zigzag_rle.sv | 253 +++++++++++++++++++++++++
 tb/tb_y_zigzag_rle.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/y_zigzag_rle.sv
`default_nettype none
// ============================================================================
// y_zigzag_rle : captures 8x8 quantized Y blocks, zig-zag scans them and emits
//                JPEG-style DC / AC(run,size,value) / ZRL / EOB symbols.
// Rev 1.0
// ============================================================================
module y_zigzag_rle #(
    parameter int COEFF_W = 11
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable,
    input  logic [7:0][7:0][COEFF_W-1:0] Q,
    input  logic                         dc_clr,
    output logic                         sym_valid,
    input  logic                         sym_ready,
    output logic                         sym_is_dc,
    output logic [3:0]                   sym_run,
    output logic [3:0]                   sym_size,
    output logic [COEFF_W:0]             sym_value,
    output logic                         sym_last,
    output logic                         overflow
);
    localparam int VW = COEFF_W + 1;

    typedef enum logic [2:0] {S_IDLE, S_DC, S_SCAN, S_ZRL, S_EOB} state_t;

    // Walks the anti-diagonals to find the raster position of zig-zag index k.
    function automatic logic [5:0] zz_pos(input int k);
        int idx;
        int r;
        int c;
        logic [5:0] res;
        idx = 0;
        res = '0;
        for (int s = 0; s < 15; s++) begin
            for (int i = 0; i < 8; i++) begin
                r = (s % 2 == 0) ? ((s < 8 ? s : 7) - i) : ((s < 8 ? 0 : s - 7) + i);
                c = s - r;
                if (r >= 0 && r < 8 && c >= 0 && c < 8) begin
                    if (idx == k) res = 6'(r * 8 + c);
                    idx++;
                end
            end
        end
        return res;
    endfunction

    function automatic logic [3:0] size_of(input logic [VW-1:0] v);
        logic [VW-1:0] mag;
        logic [3:0]    sz;
        mag = v[VW-1] ? (~v + {{(VW-1){1'b0}}, 1'b1}) : v;
        sz  = '0;
        for (int n = 0; n < VW; n++) begin
            if (mag[n]) sz = 4'(n + 1);
        end
        return sz;
    endfunction

    function automatic logic [VW-1:0] sext(input logic [COEFF_W-1:0] x);
        return {x[COEFF_W-1], x};
    endfunction

    logic [5:0] zz_tab [64];

    for (genvar gi = 0; gi < 64; gi++) begin : g_zz
        assign zz_tab[gi] = zz_pos(gi);
    end

    logic [63:0][COEFF_W-1:0] hold_q, hold_d, work_q, work_d;
    logic                     hold_full_q, hold_full_d;
    state_t                   state_q, state_d;
    logic [5:0]               k_q, k_d, run_q, run_d;
    logic [COEFF_W-1:0]       pred_q, pred_d;
    logic                     overflow_q, overflow_d;
    logic                     sym_valid_q, sym_valid_d, sym_is_dc_q, sym_is_dc_d;
    logic [3:0]               sym_run_q, sym_run_d, sym_size_q, sym_size_d;
    logic [VW-1:0]            sym_value_q, sym_value_d;
    logic                     sym_last_q, sym_last_d;

    logic                     transfer, go_idle, eval_go;
    logic [5:0]               eval_k, eval_run;
    logic [COEFF_W-1:0]       coeff, pred_eff;
    logic [VW-1:0]            coeff_ext, dc_diff;

    always_comb begin
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        work_d      = work_q;
        state_d     = state_q;
        k_d         = k_q;
        run_d       = run_q;
        pred_d      = dc_clr ? '0 : pred_q;
        overflow_d  = overflow_q;
        sym_valid_d = sym_valid_q;
        sym_is_dc_d = sym_is_dc_q;
        sym_run_d   = sym_run_q;
        sym_size_d  = sym_size_q;
        sym_value_d = sym_value_q;
        sym_last_d  = sym_last_q;
        go_idle     = 1'b0;
        eval_go     = 1'b0;
        eval_k      = k_q;
        eval_run    = run_q;
        coeff       = '0;
        coeff_ext   = '0;
        pred_eff    = dc_clr ? '0 : pred_q;
        dc_diff     = sext(hold_q[0]) - sext(pred_eff);
        transfer    = (state_q == S_IDLE) && hold_full_q;

        case (state_q)
            S_IDLE: begin
                if (transfer) begin
                    work_d      = hold_q;
                    state_d     = S_DC;
                    sym_valid_d = 1'b1;
                    sym_is_dc_d = 1'b1;
                    sym_run_d   = '0;
                    sym_size_d  = size_of(dc_diff);
                    sym_value_d = dc_diff;
                    sym_last_d  = 1'b0;
                end
            end
            S_DC: begin
                if (sym_ready) begin
                    if (!dc_clr) pred_d = work_q[0];
                    eval_go  = 1'b1;
                    eval_k   = 6'd1;
                    eval_run = '0;
                end
            end
            S_SCAN: begin
                // The output register doubles as the pending-symbol slot, so the
                // next coefficient is examined on the same edge the current one leaves.
                if (!sym_valid_q || sym_ready) begin
                    if (sym_valid_q && sym_last_q) go_idle = 1'b1;
                    else                           eval_go = 1'b1;
                end
            end
            S_ZRL: begin
                if (sym_ready) begin
                    eval_go  = 1'b1;
                    eval_run = run_q - 6'd16;
                end
            end
            S_EOB: begin
                if (sym_ready) go_idle = 1'b1;
            end
            default: go_idle = 1'b1;
        endcase

        if (go_idle) begin
            state_d     = S_IDLE;
            sym_valid_d = 1'b0;
            sym_is_dc_d = 1'b0;
            sym_run_d   = '0;
            sym_size_d  = '0;
            sym_value_d = '0;
            sym_last_d  = 1'b0;
        end

        if (eval_go) begin
            coeff       = work_q[zz_tab[eval_k]];
            coeff_ext   = sext(coeff);
            sym_is_dc_d = 1'b0;
            sym_run_d   = '0;
            sym_size_d  = '0;
            sym_value_d = '0;
            sym_last_d  = 1'b0;
            if (coeff == '0) begin
                if (eval_k == 6'd63) begin
                    state_d     = S_EOB;
                    sym_valid_d = 1'b1;
                    sym_last_d  = 1'b1;
                end else begin
                    state_d     = S_SCAN;
                    sym_valid_d = 1'b0;
                    k_d         = eval_k + 6'd1;
                    run_d       = eval_run + 6'd1;
                end
            end else if (eval_run >= 6'd16) begin
                state_d     = S_ZRL;
                sym_valid_d = 1'b1;
                sym_run_d   = 4'd15;
                k_d         = eval_k;
                run_d       = eval_run;
            end else begin
                state_d     = S_SCAN;
                sym_valid_d = 1'b1;
                sym_run_d   = eval_run[3:0];
                sym_size_d  = size_of(coeff_ext);
                sym_value_d = coeff_ext;
                sym_last_d  = (eval_k == 6'd63);
                k_d         = (eval_k == 6'd63) ? eval_k : eval_k + 6'd1;
                run_d       = '0;
            end
        end

        if (transfer) hold_full_d = 1'b0;
        if (enable) begin
            if (!hold_full_q || transfer) begin
                hold_d      = Q;
                hold_full_d = 1'b1;
            end else begin
                overflow_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            work_q      <= '0;
            state_q     <= S_IDLE;
            k_q         <= '0;
            run_q       <= '0;
            pred_q      <= '0;
            overflow_q  <= 1'b0;
            sym_valid_q <= 1'b0;
            sym_is_dc_q <= 1'b0;
            sym_run_q   <= '0;
            sym_size_q  <= '0;
            sym_value_q <= '0;
            sym_last_q  <= 1'b0;
        end else begin
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            work_q      <= work_d;
            state_q     <= state_d;
            k_q         <= k_d;
            run_q       <= run_d;
            pred_q      <= pred_d;
            overflow_q  <= overflow_d;
            sym_valid_q <= sym_valid_d;
            sym_is_dc_q <= sym_is_dc_d;
            sym_run_q   <= sym_run_d;
            sym_size_q  <= sym_size_d;
            sym_value_q <= sym_value_d;
            sym_last_q  <= sym_last_d;
        end
    end

    assign sym_valid = sym_valid_q;
    assign sym_is_dc = sym_is_dc_q;
    assign sym_run   = sym_run_q;
    assign sym_size  = sym_size_q;
    assign sym_value = sym_value_q;
    assign sym_last  = sym_last_q;
    assign overflow  = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_y_zigzag_rle.sv
`default_nettype none
// ============================================================================
// tb_y_zigzag_rle : randomized self-checking bench with a list-based symbol model.
// Rev 1.0
// ============================================================================
module tb_y_zigzag_rle;
    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   enable = 1'b0;
    logic [7:0][7:0][10:0]  q_blk = '0;
    logic                   dc_clr = 1'b0;
    logic                   sym_ready = 1'b0;
    logic                   sym_valid, sym_is_dc, sym_last, overflow;
    logic [3:0]             sym_run, sym_size;
    logic [11:0]            sym_value;

    int total = 0;
    int bad   = 0;
    int model_pred = 0;
    logic [21:0] exp_q [$];

    int zz [64] = '{0, 1, 8,16, 9, 2, 3,10,17,24,32,25,18,11, 4, 5,
                   12,19,26,33,40,48,41,34,27,20,13, 6, 7,14,21,28,
                   35,42,49,56,57,50,43,36,29,22,15,23,30,37,44,51,
                   58,59,52,45,38,31,39,46,53,60,61,54,47,55,62,63};

    y_zigzag_rle #(.COEFF_W(11)) dut (
        .clk(clk), .rst(rst), .enable(enable), .Q(q_blk), .dc_clr(dc_clr),
        .sym_valid(sym_valid), .sym_ready(sym_ready), .sym_is_dc(sym_is_dc),
        .sym_run(sym_run), .sym_size(sym_size), .sym_value(sym_value),
        .sym_last(sym_last), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [21:0] obs();
        return {sym_is_dc, sym_run, sym_size, sym_value, sym_last};
    endfunction

    function automatic int size_cat(input int v);
        int a;
        a = (v < 0) ? -v : v;
        return $clog2(a + 1);
    endfunction

    task automatic push(input int dc, input int run, input int v, input int last);
        exp_q.push_back({1'(dc), 4'(run), 4'(size_cat(v)), 12'(v), 1'(last)});
    endtask

    // Reference: DC difference, then zero runs split into 16-long ZRLs, EOB if tail is zero.
    task automatic model_block(input logic [7:0][7:0][10:0] b);
        int v, run, d, n;
        d = int'($signed(b[0][0]));
        push(1, 0, d - model_pred, 0);
        model_pred = d;
        run = 0;
        v = 0;
        for (int k = 1; k < 64; k++) begin
            n = zz[k];
            v = int'($signed(b[n / 8][n % 8]));
            if (v == 0) run++;
            else begin
                while (run >= 16) begin
                    push(0, 15, 0, 0);
                    run -= 16;
                end
                push(0, run, v, (k == 63) ? 1 : 0);
                run = 0;
            end
        end
        if (v == 0) push(0, 0, 0, 1);
    endtask

    task automatic send_block(input logic [7:0][7:0][10:0] b);
        @(negedge clk);
        q_blk  = b;
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        model_block(b);
    endtask

    function automatic logic [7:0][7:0][10:0] rand_block(input int pct_nz);
        logic [7:0][7:0][10:0] b;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                b[r][c] = ($urandom_range(0, 99) < pct_nz) ?
                          11'($urandom_range(0, 2047)) : 11'd0;
        return b;
    endfunction

    task automatic drain(input int n, input int pct);
        int  got, cyc;
        bit  stalled, r;
        logic [21:0] prev, cur;
        got = 0; cyc = 0; stalled = 0; prev = '0;
        while (got < n && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            cur = obs();
            if (stalled) begin
                chk("stall_valid", 32'(sym_valid), 32'd1);
                chk("stall_stable", 32'(cur), 32'(prev));
            end
            r = ($urandom_range(0, 99) < pct);
            sym_ready = r;
            stalled = 0;
            if (sym_valid) begin
                if (r) begin
                    if (exp_q.size() != 0) chk("symbol", 32'(cur), 32'(exp_q.pop_front()));
                    else begin
                        total++;
                        assert (exp_q.size() != 0) else begin
                            bad++;
                            $error("FAIL extra_symbol observed=%h expected=none", cur);
                        end
                    end
                    got++;
                end else begin
                    stalled = 1;
                    prev = cur;
                end
            end
        end
        if (got < n) chk("drain_timeout", 32'(got), 32'(n));
        @(negedge clk);
        sym_ready = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        repeat (3) @(negedge clk);
        chk(tag, 32'(sym_valid), 32'd0);
        chk({tag, "_queue"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        logic [7:0][7:0][10:0] b, b2, b3;
        int n;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(sym_valid), 32'd0);
        chk("rst_outs", 32'(obs()), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        rst = 1'b0;

        // DC-only block with latency check, then an identical block
        b = '0;
        b[0][0] = 11'd50;
        @(negedge clk);
        q_blk = b;
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        model_block(b);
        chk("lat_edge_n", 32'(sym_valid), 32'd0);
        @(negedge clk);
        chk("lat_edge_n1", 32'(sym_valid), 32'd1);
        chk("dc50_first", 32'(obs()), 32'(exp_q[0]));
        drain(2, 100);
        send_block(b);
        drain(2, 100);
        check_idle("idle_dc");

        // Zig-zag ramp: value k+1 at index k, no EOB
        b = '0;
        for (int k = 0; k < 64; k++) begin
            n = zz[k];
            b[n / 8][n % 8] = 11'(k + 1);
        end
        send_block(b);
        drain(64, 100);
        check_idle("idle_ramp");

        // Two ZRLs before a single AC at k=40
        b = '0;
        b[0][0] = 11'd1;
        n = zz[40];
        b[n / 8][n % 8] = 11'h7FD;
        send_block(b);
        drain(5, 100);
        check_idle("idle_zrl");

        // Same block and random blocks under 30% backpressure
        send_block(b);
        drain(5, 30);
        for (int i = 0; i < 4; i++) begin
            b2 = rand_block((i % 2 == 0) ? 15 : 60);
            send_block(b2);
            drain(exp_q.size(), (i < 2) ? 30 : 100);
        end
        check_idle("idle_rand");

        // Overflow: three back-to-back pulses with the consumer stalled
        chk("ovf_before", 32'(overflow), 32'd0);
        b  = rand_block(20);
        b2 = rand_block(20);
        b3 = rand_block(20);
        @(negedge clk); q_blk = b;  enable = 1'b1; model_block(b);
        @(negedge clk); q_blk = b2; model_block(b2);
        @(negedge clk); q_blk = b3;
        @(negedge clk); enable = 1'b0;
        chk("ovf_set", 32'(overflow), 32'd1);
        drain(exp_q.size(), 50);
        check_idle("idle_ovf");

        // dc_clr between two DC=100 blocks
        b = '0;
        b[0][0] = 11'd100;
        b[1][1] = 11'd3;
        send_block(b);
        drain(exp_q.size(), 100);
        @(negedge clk); dc_clr = 1'b1;
        @(negedge clk); dc_clr = 1'b0;
        model_pred = 0;
        send_block(b);
        chk("dcclr_diff", 32'(exp_q[0][12:1]), 32'd100);
        drain(exp_q.size(), 100);
        check_idle("idle_dcclr");

        // Reset in the middle of the zero scan
        b = '0;
        b[0][0] = 11'd5;
        n = zz[60];
        b[n / 8][n % 8] = 11'd9;
        send_block(b);
        drain(1, 100);
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_valid", 32'(sym_valid), 32'd0);
        chk("midrst_outs", 32'(obs()), 32'd0);
        chk("midrst_ovf", 32'(overflow), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        model_pred = 0;
        b[0][0] = 11'd7;
        send_block(b);
        drain(exp_q.size(), 100);
        check_idle("idle_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
